// File: rtl/backdoor_spi_slave.sv
// SPI mode-0 slave giving an external master register access; everything runs on i_SYSCLK.
// Optional BACKDOOR_SPI_FULL_DUPLEX_EN: shift i_DATA_OUT out on o_MISO during write frames too.
module backdoor_spi_slave #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BUFFER_WIDTH  = 2
) (
    input  logic                     i_SYSCLK,
    input  logic                     i_RST_N,
    input  logic                     i_BCLK,
    input  logic                     i_SS,
    input  logic                     i_MOSI,
    input  logic [DATA_WIDTH-1:0]    i_DATA_OUT,
    output logic                     o_MISO,
    output logic [ADDRESS_WIDTH-2:0] o_ADDR,
    output logic [DATA_WIDTH-1:0]    o_DATA_IN,
    output logic                     o_DOUT_VALID
);
    localparam int AW = ADDRESS_WIDTH - 1;
    localparam int CW = $clog2((DATA_WIDTH > AW ? DATA_WIDTH : AW) + 1);
    localparam int WW = $clog2(BUFFER_WIDTH + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE} state_t;
    state_t state_q, state_d;

    logic [1:0] bclk_sync, ss_sync, mosi_sync;
    logic       bclk_prev;
    logic       bclk_rise, ss_hi, mosi_s;
    logic [CW-1:0] bit_cnt;
    logic [WW-1:0] wait_cnt;
    logic          cmd_rd;
    logic [AW-2:0] addr_sh;
    logic [DATA_WIDTH-2:0] data_sh;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [AW-1:0]         addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic last_addr, last_data, wait_done;
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
    logic load_pend;
`endif

    always_ff @(posedge i_SYSCLK) begin
        if (!i_RST_N) begin
            bclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], i_BCLK};
            ss_sync   <= {ss_sync[0], i_SS};
            mosi_sync <= {mosi_sync[0], i_MOSI};
            bclk_prev <= bclk_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign ss_hi     = ss_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign addr_next = {addr_sh, mosi_s};
    assign data_next = {data_sh, mosi_s};
    assign last_addr = bclk_rise && (bit_cnt == CW'(AW - 1));
    assign last_data = bclk_rise && (bit_cnt == CW'(DATA_WIDTH - 1));
    assign wait_done = (wait_cnt == WW'(BUFFER_WIDTH - 1));

    always_ff @(posedge i_SYSCLK) begin
        if (!i_RST_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_hi) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bclk_rise) state_d = S_ADDR;
                S_ADDR:  if (last_addr) state_d = cmd_rd ? S_RWAIT : S_WDATA;
                S_WDATA: if (last_data) state_d = S_DONE;
                S_RWAIT: if (wait_done) state_d = S_RDATA;
                S_RDATA: if (last_data) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // o_DOUT_VALID is a one-cycle strobe with no backpressure; o_DATA_IN holds until the next completed write.
    always_ff @(posedge i_SYSCLK) begin
        if (!i_RST_N) begin
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            cmd_rd       <= 1'b0;
            addr_sh      <= '0;
            data_sh      <= '0;
            tx_sh        <= '0;
            o_MISO       <= 1'b0;
            o_ADDR       <= '0;
            o_DATA_IN    <= '0;
            o_DOUT_VALID <= 1'b0;
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
            load_pend    <= 1'b0;
`endif
        end else begin
            o_DOUT_VALID <= 1'b0;
            if (ss_hi) begin
                bit_cnt  <= '0;
                wait_cnt <= '0;
                o_MISO   <= 1'b0;
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
                load_pend <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: if (bclk_rise) begin
                        cmd_rd  <= mosi_s;
                        bit_cnt <= '0;
                        tx_sh   <= '0;
                    end
                    S_ADDR: if (bclk_rise) begin
                        addr_sh <= addr_next[AW-2:0];
                        if (last_addr) begin
                            o_ADDR   <= addr_next;
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
                            load_pend <= ~mosi_s | ~cmd_rd;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    S_RWAIT: begin
                        if (wait_done) tx_sh <= i_DATA_OUT;
                        else           wait_cnt <= wait_cnt + WW'(1);
                    end
                    S_RDATA: if (bclk_rise) begin
                        o_MISO  <= tx_sh[DATA_WIDTH-1];
                        tx_sh   <= tx_sh << 1;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    S_WDATA: begin
                        if (bclk_rise) begin
                            data_sh <= data_next[DATA_WIDTH-2:0];
                            bit_cnt <= bit_cnt + CW'(1);
                            if (last_data) begin
                                o_DATA_IN    <= data_next;
                                o_DOUT_VALID <= 1'b1;
                            end
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
                            o_MISO <= tx_sh[DATA_WIDTH-1];
                            tx_sh  <= tx_sh << 1;
`endif
                        end
`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
                        // A late parallel load overrides a same-cycle shift.
                        if (load_pend) begin
                            if (wait_done) begin
                                tx_sh     <= i_DATA_OUT;
                                load_pend <= 1'b0;
                            end else begin
                                wait_cnt <= wait_cnt + WW'(1);
                            end
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_backdoor_spi_slave.sv
// Directed bench for backdoor_spi_slave: table of read/write frames plus abort and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_backdoor_spi_slave;
    logic        i_SYSCLK = 1'b0;
    logic        i_RST_N  = 1'b0;
    logic        i_BCLK   = 1'b0;
    logic        i_SS     = 1'b1;
    logic        i_MOSI   = 1'b0;
    logic [31:0] i_DATA_OUT = '0;
    logic        o_MISO;
    logic [6:0]  o_ADDR;
    logic [31:0] o_DATA_IN;
    logic        o_DOUT_VALID;

`ifdef BACKDOOR_SPI_FULL_DUPLEX_EN
    localparam bit FD = 1'b1;
`else
    localparam bit FD = 1'b0;
`endif

    backdoor_spi_slave dut (
        .i_SYSCLK(i_SYSCLK), .i_RST_N(i_RST_N), .i_BCLK(i_BCLK), .i_SS(i_SS),
        .i_MOSI(i_MOSI), .i_DATA_OUT(i_DATA_OUT), .o_MISO(o_MISO), .o_ADDR(o_ADDR),
        .o_DATA_IN(o_DATA_IN), .o_DOUT_VALID(o_DOUT_VALID)
    );

    always #10 i_SYSCLK = ~i_SYSCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0, hi_cnt = 0, hdr_pulse = 0;
    logic [31:0] cap_data = '0;
    logic vprev = 1'b0;
    logic in_hdr = 1'b0;
    logic [31:0] last_wr = '0;

    // Strobe monitor: counts pulses, high cycles and any pulse during the header.
    always @(negedge i_SYSCLK) begin
        if (o_DOUT_VALID === 1'b1) begin
            hi_cnt = hi_cnt + 1;
            if (!vprev) begin
                pulse_cnt = pulse_cnt + 1;
                cap_data  = o_DATA_IN;
            end
            if (in_hdr) hdr_pulse = hdr_pulse + 1;
        end
        vprev = o_DOUT_VALID;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_frame(input bit rd, input logic [6:0] addr, input logic [31:0] wdata,
                            input int half, input int nbits, output logic [31:0] rx);
        logic [39:0] bits;
        bits = {rd, addr, wdata};
        rx = '0;
        i_SS = 1'b0;
        in_hdr = 1'b1;
        #(half);
        for (int i = 0; i < nbits; i++) begin
            i_MOSI = bits[39-i];
            #(half);
            i_BCLK = 1'b1;
            #(half);
            if (i >= 8) rx = {rx[30:0], o_MISO};
            i_BCLK = 1'b0;
            if (i == 7) begin
                #150;
                in_hdr = 1'b0;
            end
        end
    endtask

    task automatic end_frame(input int half);
        #(half);
        i_SS = 1'b1;
        #200;
    endtask

    typedef struct {
        bit          rd;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          half;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int p0, h0, d0;
        logic [31:0] rx, exp_rx;
        p0 = pulse_cnt; h0 = hi_cnt; d0 = hdr_pulse;
        i_DATA_OUT = v.dout;
        do_frame(v.rd, v.addr, v.wdata, v.half, 40, rx);
        exp_rx = (v.rd || FD) ? v.dout : 32'h0;
        chk({tag, " o_ADDR"}, {25'd0, o_ADDR}, {25'd0, v.addr});
        chk({tag, " miso_word"}, rx, exp_rx);
        chk({tag, " hdr_strobe"}, hdr_pulse - d0, 0);
        if (!v.rd) begin
            last_wr = v.wdata;
            chk({tag, " strobe_count"}, pulse_cnt - p0, 1);
            chk({tag, " strobe_cycles"}, hi_cnt - h0, 1);
            chk({tag, " strobe_data"}, cap_data, v.wdata);
        end else begin
            chk({tag, " strobe_count"}, pulse_cnt - p0, 0);
        end
        end_frame(v.half);
        chk({tag, " o_DATA_IN"}, o_DATA_IN, last_wr);
        chk({tag, " miso_idle"}, {31'd0, o_MISO}, 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] rx;
        int p0;
        vecs[0] = '{1'b1, 7'b1100101, 32'h0,        32'h12345678, 100};
        vecs[1] = '{1'b1, 7'b1100101, 32'h0,        32'hF0F0F0F0, 100};
        vecs[2] = '{1'b1, 7'b1100101, 32'h0,        32'h00000000, 100};
        vecs[3] = '{1'b1, 7'b1100101, 32'h0,        32'hFFFFFFFF, 100};
        vecs[4] = '{1'b0, 7'b0101010, 32'hF0F0F0F0, 32'h0F0F0F0F, 100};
        vecs[5] = '{1'b0, 7'h00,      32'h00000000, 32'hA5A5A5A5, 100};
        vecs[6] = '{1'b0, 7'h7F,      32'hFFFFFFFF, 32'h5A5A5A5A, 100};
        vecs[7] = '{1'b0, 7'h65,      32'h12345678, 32'h0F0F0F0F, 100};
        vecs[8] = '{1'b1, 7'b1100101, 32'h0,        32'h12345678, 1060};
        vecs[9] = '{1'b0, 7'b0101010, 32'hF0F0F0F0, 32'h0F0F0F0F, 1060};

        repeat (5) @(posedge i_SYSCLK);
        @(negedge i_SYSCLK);
        chk("reset o_MISO", {31'd0, o_MISO}, 32'h0);
        chk("reset o_ADDR", {25'd0, o_ADDR}, 32'h0);
        chk("reset o_DATA_IN", o_DATA_IN, 32'h0);
        chk("reset o_DOUT_VALID", {31'd0, o_DOUT_VALID}, 32'h0);
        i_RST_N = 1'b1;
        repeat (5) @(negedge i_SYSCLK);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort after 20 write data bits: no strobe, data unchanged, next frame fine.
        p0 = pulse_cnt;
        i_DATA_OUT = 32'h0;
        do_frame(1'b0, 7'h11, 32'hDEADBEEF, 100, 28, rx);
        end_frame(100);
        chk("abort strobe_count", pulse_cnt - p0, 0);
        chk("abort o_DATA_IN", o_DATA_IN, last_wr);
        chk("abort o_MISO", {31'd0, o_MISO}, 32'h0);
        run_vec('{1'b0, 7'h11, 32'hCAFEF00D, 32'h0F0F0F0F, 100}, "after_abort");

        // Reset asserted mid-way through a read data phase.
        i_DATA_OUT = 32'hFFFFFFFF;
        do_frame(1'b1, 7'h55, 32'h0, 100, 18, rx);
        chk("midrst pre o_MISO", {31'd0, o_MISO}, 32'h1);
        chk("midrst pre o_ADDR", {25'd0, o_ADDR}, 32'h55);
        @(negedge i_SYSCLK);
        i_RST_N = 1'b0;
        @(posedge i_SYSCLK);
        #1;
        chk("midrst o_MISO", {31'd0, o_MISO}, 32'h0);
        chk("midrst o_ADDR", {25'd0, o_ADDR}, 32'h0);
        chk("midrst o_DATA_IN", o_DATA_IN, 32'h0);
        chk("midrst o_DOUT_VALID", {31'd0, o_DOUT_VALID}, 32'h0);
        @(negedge i_SYSCLK);
        i_RST_N = 1'b1;
        last_wr = 32'h0;
        end_frame(100);
        run_vec('{1'b0, 7'h33, 32'h600DC0DE, 32'h0F0F0F0F, 100}, "after_reset");
        run_vec('{1'b1, 7'h33, 32'h0, 32'h89ABCDEF, 100}, "after_reset_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
